// File: rtl/hid_mon_pkg.sv
// Shared encodings for the HID activity monitor: link states, device types,
// LED display modes and the thermometer helper used by the bar display.
package hid_mon_pkg;

  typedef enum logic [1:0] {
    LINK_IDLE   = 2'd0,
    LINK_ACTIVE = 2'd1,
    LINK_ERROR  = 2'd2
  } link_e;

  typedef enum logic [1:0] {
    TYP_NONE  = 2'd0,
    TYP_KBD   = 2'd1,
    TYP_MOUSE = 2'd2,
    TYP_GAME  = 2'd3
  } typ_e;

  typedef enum logic [1:0] {
    LED_STATUS = 2'd0,
    LED_TOTAL  = 2'd1,
    LED_RATE   = 2'd2,
    LED_BAR    = 2'd3
  } led_mode_e;

  // Lights bits [n-1:0]; n above 8 is treated as 8.
  function automatic logic [7:0] therm8(input logic [3:0] n);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      t[i] = (4'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/hid_activity_monitor_if.sv
// Bundle between usb_hid_host-side logic and the activity monitor.
// master drives the host-side inputs, slave is the monitor itself.
interface hid_activity_monitor_if #(
  parameter int CNT_W = 16
);
  logic             report;
  logic [1:0]       typ;
  logic             conerr;
  logic             clr;
  logic [1:0]       led_mode;
  logic [CNT_W-1:0] rep_total;
  logic [CNT_W-1:0] rep_kbd;
  logic [CNT_W-1:0] rep_mouse;
  logic [CNT_W-1:0] rep_game;
  logic [CNT_W-1:0] rate;
  logic             rate_vld;
  logic             act;
  logic [1:0]       link;
  logic             dev_new;
  logic [7:0]       led;

  modport master (
    output report, typ, conerr, clr, led_mode,
    input  rep_total, rep_kbd, rep_mouse, rep_game, rate, rate_vld,
           act, link, dev_new, led
  );

  modport slave (
    input  report, typ, conerr, clr, led_mode,
    output rep_total, rep_kbd, rep_mouse, rep_game, rate, rate_vld,
           act, link, dev_new, led
  );
endinterface

// File: rtl/hid_activity_monitor_sat_counter.sv
// Saturating up-counter with clear priority; restart reloads with 0 or 1
// so an increment on the restart cycle lands in the new count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         restart,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  // Count register: clear beats restart beats increment; holds at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CNT_ZERO;
    end else if (clr) begin
      q <= CNT_ZERO;
    end else if (restart) begin
      q <= inc ? CNT_ONE : CNT_ZERO;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_ONE;
    end else begin
      q <= q;
    end
  end
endmodule

// File: rtl/hid_activity_monitor.sv
// Report counters, windowed rate, activity stretcher, link FSM and LED
// display for a USB HID host, all on the 12 MHz USB clock.
module hid_activity_monitor
  import hid_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STRETCH_CYC = 120000,
  parameter int WINDOW_CYC  = 12000000,
  parameter int BLINK_W     = 22,
  parameter int BAR_SHIFT   = 3
) (
  input logic                   usbclk,
  input logic                   usbrst,
  hid_activity_monitor_if.slave mon
);
  localparam int WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int ST_W  = $clog2(STRETCH_CYC + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYC - 1);
  localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
  localparam logic [ST_W-1:0]    ST_LOAD    = ST_W'(STRETCH_CYC);
  localparam logic [ST_W-1:0]    ST_ONE     = ST_W'(1);
  localparam logic [ST_W-1:0]    ST_ZERO    = {ST_W{1'b0}};
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   BYTE_MAX   = CNT_W'(255);
  localparam logic [CNT_W-1:0]   BAR_FULL   = CNT_W'(8);

  typ_e               typ_s;
  led_mode_e          mode_s;
  logic               inc_kbd_s, inc_mouse_s, inc_game_s;
  logic [CNT_W-1:0]   win_cnt_s;
  logic [WIN_W-1:0]   win_r;
  logic               win_tc_s;
  logic [CNT_W-1:0]   rate_r;
  logic               rate_vld_r;
  logic [ST_W-1:0]    st_r;
  logic               act_r;
  logic [BLINK_W-1:0] blink_r;
  link_e              link_r, link_nxt_s;
  logic               dev_new_s, dev_new_r;
  logic [CNT_W-1:0]   rate_sh_s;
  logic [3:0]         bar_n_s;
  logic               blink_on_s;
  logic [7:0]         led_nxt_s, led_r;

  assign typ_s       = typ_e'(mon.typ);
  assign mode_s      = led_mode_e'(mon.led_mode);
  assign inc_kbd_s   = mon.report && (typ_s == TYP_KBD);
  assign inc_mouse_s = mon.report && (typ_s == TYP_MOUSE);
  assign inc_game_s  = mon.report && (typ_s == TYP_GAME);
  assign win_tc_s    = (win_r == WIN_LAST);

  sat_counter #(.W(CNT_W)) u_cnt_total (.clk(usbclk), .rst(usbrst), .inc(mon.report),
    .clr(mon.clr), .restart(1'b0), .q(mon.rep_total));
  sat_counter #(.W(CNT_W)) u_cnt_kbd   (.clk(usbclk), .rst(usbrst), .inc(inc_kbd_s),
    .clr(mon.clr), .restart(1'b0), .q(mon.rep_kbd));
  sat_counter #(.W(CNT_W)) u_cnt_mouse (.clk(usbclk), .rst(usbrst), .inc(inc_mouse_s),
    .clr(mon.clr), .restart(1'b0), .q(mon.rep_mouse));
  sat_counter #(.W(CNT_W)) u_cnt_game  (.clk(usbclk), .rst(usbrst), .inc(inc_game_s),
    .clr(mon.clr), .restart(1'b0), .q(mon.rep_game));
  // A report on the terminal cycle opens the new window at 1.
  sat_counter #(.W(CNT_W)) u_cnt_win   (.clk(usbclk), .rst(usbrst), .inc(mon.report),
    .clr(mon.clr), .restart(win_tc_s), .q(win_cnt_s));

  // Free-running window phase; clr does not disturb it.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      win_r <= {WIN_W{1'b0}};
    end else if (win_tc_s) begin
      win_r <= {WIN_W{1'b0}};
    end else begin
      win_r <= win_r + WIN_ONE;
    end
  end

  // Rate latch at window end.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      rate_r     <= CNT_ZERO;
      rate_vld_r <= 1'b0;
    end else begin
      rate_vld_r <= win_tc_s;
      if (mon.clr) begin
        rate_r <= CNT_ZERO;
      end else if (win_tc_s) begin
        rate_r <= win_cnt_s;
      end else begin
        rate_r <= rate_r;
      end
    end
  end

  // Retriggerable stretcher: act stays high for STRETCH_CYC cycles after the last report.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      st_r  <= ST_ZERO;
      act_r <= 1'b0;
    end else begin
      act_r <= mon.report || (st_r > ST_ONE);
      if (mon.report) begin
        st_r <= ST_LOAD;
      end else if (st_r != ST_ZERO) begin
        st_r <= st_r - ST_ONE;
      end else begin
        st_r <= st_r;
      end
    end
  end

  // Blink divider, free-running.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      blink_r <= {BLINK_W{1'b0}};
    end else begin
      blink_r <= blink_r + BLINK_ONE;
    end
  end

  // Link next-state; conerr overrides everything.
  always_comb begin
    link_nxt_s = link_r;
    dev_new_s  = 1'b0;
    case (link_r)
      LINK_IDLE: begin
        if (mon.conerr) begin
          link_nxt_s = LINK_ERROR;
        end else if (typ_s != TYP_NONE) begin
          link_nxt_s = LINK_ACTIVE;
          dev_new_s  = 1'b1;
        end else begin
          link_nxt_s = LINK_IDLE;
        end
      end
      LINK_ACTIVE: begin
        if (mon.conerr) begin
          link_nxt_s = LINK_ERROR;
        end else if (typ_s == TYP_NONE) begin
          link_nxt_s = LINK_IDLE;
        end else begin
          link_nxt_s = LINK_ACTIVE;
        end
      end
      LINK_ERROR: begin
        if (mon.conerr) begin
          link_nxt_s = LINK_ERROR;
        end else if (typ_s != TYP_NONE) begin
          link_nxt_s = LINK_ACTIVE;
        end else begin
          link_nxt_s = LINK_IDLE;
        end
      end
      default: begin
        link_nxt_s = LINK_IDLE;
      end
    endcase
  end

  // Link state and dev_new registers.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      link_r    <= LINK_IDLE;
      dev_new_r <= 1'b0;
    end else begin
      link_r    <= link_nxt_s;
      dev_new_r <= dev_new_s;
    end
  end

  assign rate_sh_s  = rate_r >> BAR_SHIFT;
  assign bar_n_s    = (rate_sh_s > BAR_FULL) ? 4'd8 : rate_sh_s[3:0];
  assign blink_on_s = (link_r == LINK_ERROR) && blink_r[BLINK_W-1];

  // LED source select.
  always_comb begin
    led_nxt_s = 8'h00;
    case (mode_s)
      LED_STATUS: led_nxt_s = {1'b0, mon.rep_total[6], 2'b00, blink_on_s, act_r, mon.typ};
      LED_TOTAL:  led_nxt_s = mon.rep_total[7:0];
      LED_RATE:   led_nxt_s = (rate_r > BYTE_MAX) ? 8'hFF : rate_r[7:0];
      LED_BAR:    led_nxt_s = therm8(bar_n_s);
      default:    led_nxt_s = 8'h00;
    endcase
  end

  // LED register.
  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      led_r <= 8'h00;
    end else begin
      led_r <= led_nxt_s;
    end
  end

  assign mon.rate     = rate_r;
  assign mon.rate_vld = rate_vld_r;
  assign mon.act      = act_r;
  assign mon.link     = link_r;
  assign mon.dev_new  = dev_new_r;
  assign mon.led      = led_r;
endmodule

// File: doc/hid_activity_monitor.md
Name: hid_activity_monitor

Overview:
- Parametrised successor to the single report-counter LED logic in the USB HID host board tops.
- Sits on the 12 MHz USB clock next to usb_hid_host. Consumes its report strobe, device type and connection-error flag.
- Produces the following, plus an 8-bit LED bus with four selectable display modes:
  - per-type saturating report counters;
  - a windowed report-rate measurement;
  - a retriggerable activity stretcher;
  - a link-state machine.

Parameters:
- CNT_W, 16, width of all report counters and the rate result.
- STRETCH_CYC, 120000, activity pulse length in cycles (10 ms at 12 MHz).
- WINDOW_CYC, 12000000, rate measurement window in cycles (1 s at 12 MHz).
- BLINK_W, 22, error blink divider width; LED toggles at bit BLINK_W-1.
- BAR_SHIFT, 3, rate right-shift applied before thermometer display.

Ports:
- usbclk  in  1  USB clock (12 MHz)
- usbrst  in  1  asynchronous active-high reset
- report  in  1  one-cycle report strobe from usb_hid_host
- typ  in  2  device type: 0 none, 1 keyboard, 2 mouse, 3 gamepad
- conerr  in  1  connection error level
- clr  in  1  synchronous clear of all counters and rate
- led_mode  in  2  LED display mode select
- rep_total  out  CNT_W  all reports
- rep_kbd / rep_mouse / rep_game  out  CNT_W each  per-type reports
- rate  out  CNT_W  reports counted in the last completed window
- rate_vld  out  1  one-cycle pulse when rate updates
- act  out  1  stretched activity indicator
- link  out  2  link state: 0 IDLE, 1 ACTIVE, 2 ERROR
- dev_new  out  1  one-cycle pulse on IDLE->ACTIVE
- led  out  8  display bus

Behaviour:
- Clock and reset: one clock, usbclk. Reset usbrst is asynchronous, active-high.
- Reset values:
  - all counters 0, rate 0;
  - rate_vld, act, dev_new 0;
  - link IDLE;
  - window and stretch counters 0, blink divider 0;
  - led 0.
- Counters:
  - Registered, updating the cycle after report is sampled high.
  - rep_total increments on every report. The per-type counter selected by typ also increments. typ==0 increments rep_total only.
  - All counters saturate at 2^CNT_W-1; they never wrap.
  - clr has priority over a same-cycle report: the counter becomes 0 and that report is dropped.
- Rate:
  - Free-running window counter counts 0..WINDOW_CYC-1.
  - At terminal count: rate <= window report count (saturating), rate_vld pulses, window count restarts.
  - A report coinciding with the terminal cycle is counted in the new window, so the window count restarts at 1.
  - clr zeroes rate and the window report count; the window phase is unaffected.
- Activity stretcher:
  - Report at cycle t -> act high from t+1 through t+STRETCH_CYC.
  - A report while act is high reloads the stretch counter (retrigger).
- Link FSM:
  - IDLE -> ACTIVE when typ!=0 and !conerr; dev_new pulses on this transition.
  - ACTIVE -> IDLE when typ==0.
  - Any state -> ERROR when conerr=1.
  - ERROR -> ACTIVE if typ!=0, else IDLE, on the first cycle conerr=0.
  - Reports are counted in every state.
- LED modes (led is registered, one cycle behind its sources):
  - Mode 0, STATUS:
    - led[1:0]=typ;
    - led[2]=act;
    - led[3]=blink bit when link==ERROR, else 0;
    - led[6]=rep_total[6];
    - other bits 0.
  - Mode 1, TOTAL: led=rep_total[7:0].
  - Mode 2, RATE: led=rate clamped to 255.
  - Mode 3, BAR:
    - n=min(8, rate>>BAR_SHIFT);
    - led[k]=1 for k<n (thermometer from bit 0).
  - A mode change takes effect on the next cycle.

Decomposition:
- Shared package hid_mon_pkg:
  - link state encodings IDLE/ACTIVE/ERROR;
  - typ encodings TYP_NONE/KBD/MOUSE/GAME;
  - LED mode constants STATUS/TOTAL/RATE/BAR.
- One natural sub-module, sat_counter (params W; inputs inc, clr; clr priority; saturating). Instantiated for the four report counters and the window report count.

Test Plan (bench params: CNT_W=8, STRETCH_CYC=4, WINDOW_CYC=100, BAR_SHIFT=3):
- Reset with usbrst pulsed mid-operation after 10 reports -> all outputs 0 and link=IDLE immediately, without waiting for a clock edge.
- typ=2, 300 reports -> rep_total=255, rep_mouse=255 (saturated), rep_kbd=0, rep_game=0. Then clr together with report -> all counters 0 next cycle.
- Reports at cycles 10 and 12 -> act high on cycles 11..16 (retriggered), low at 17.
- 40 reports in the first window, 1 report on terminal cycle 99 -> rate=40 with rate_vld for one cycle. The next window then reports rate>=1 including that report.
- Link sequence:
  - typ 0->1 -> link ACTIVE with a single dev_new pulse;
  - conerr=1 -> ERROR, and in mode 0 led[3] toggles every 2^(BLINK_W-1) cycles;
  - conerr=0 with typ=0 -> IDLE, no dev_new.
- rate=40, mode 3 -> led=8'b00011111. Mode 2 -> led=40. Mode 1 -> led=rep_total[7:0], each change visible one cycle later.
